// File: rtl/image_pixel_streamer.sv
// Frame source: holds one IX x IY grayscale image and streams it in raster order
// over a valid/ready interface, with sof/eol/eof flags and a one-cycle done pulse.
module image_pixel_streamer #(
  parameter int I_F_BW = 8,
  parameter int IX     = 28,
  parameter int IY     = 28,
  parameter int ADDR_W = $clog2(IX*IY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [I_F_BW-1:0] i_wr_data,
  input  logic              i_start,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [I_F_BW-1:0] o_pixel,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N_PIX = IX * IY;
  localparam int COL_W = (IX > 1) ? $clog2(IX) : 1;
  localparam int ROW_W = (IY > 1) ? $clog2(IY) : 1;
  localparam logic [ADDR_W:0]  END_PTR  = (ADDR_W+1)'(N_PIX);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IX - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IY - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [I_F_BW-1:0] mem [N_PIX];

  logic [ADDR_W:0]   rd_ptr_p0;
  logic              rd_en_p0;
  logic [I_F_BW-1:0] rd_data_p1;
  logic              vld_p1;
  logic [I_F_BW-1:0] skid_data_p2;
  logic              skid_vld_p2;
  logic [I_F_BW-1:0] pix_p2;
  logic              vld_p2;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              xfer;
  logic              last_px;
  logic              start_frame;
  logic              wr_ok;
  logic [1:0]        occ;
  logic              out_load;

  assign xfer        = vld_p2 && i_ready;
  assign last_px     = (col == LAST_COL) && (row == LAST_ROW);
  assign start_frame = (state == IDLE) && i_start;
  assign wr_ok       = i_wr_en && (state == IDLE) && ({1'b0, i_wr_addr} < END_PTR);
  assign out_load    = !vld_p2 || xfer;

  // Slots committed after this edge: output reg + skid + read in flight, minus
  // the pixel leaving now. Issuing only while below 2 keeps the skid from overflowing.
  assign occ      = 2'(vld_p2) + 2'(skid_vld_p2) + 2'(vld_p1) - 2'(xfer);
  assign rd_en_p0 = (state == STREAM) && (rd_ptr_p0 != END_PTR) && (occ < 2'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = STREAM;
      STREAM:  if (xfer && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // p0 -> p1: frame memory write port and synchronous read
  always_ff @(posedge clk) begin
    if (wr_ok) mem[i_wr_addr] <= i_wr_data;
    if (rd_en_p0) rd_data_p1 <= mem[rd_ptr_p0[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_p0 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (start_frame)   rd_ptr_p0 <= '0;
      else if (rd_en_p0) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
    end
  end

  // p1 -> p2: output register fed from the skid first, else straight from memory
  always_ff @(posedge clk) begin
    if (vld_p1) skid_data_p2 <= rd_data_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2      <= 1'b0;
      pix_p2      <= '0;
      skid_vld_p2 <= 1'b0;
    end else if (out_load) begin
      if (skid_vld_p2) begin
        vld_p2      <= 1'b1;
        pix_p2      <= skid_data_p2;
        skid_vld_p2 <= vld_p1;
      end else if (vld_p1) begin
        vld_p2 <= 1'b1;
        pix_p2 <= rd_data_p1;
      end else begin
        vld_p2 <= 1'b0;
      end
    end else if (vld_p1) begin
      skid_vld_p2 <= 1'b1;
    end
  end

  // Counters track the pixel currently held in the output register
  always_ff @(posedge clk) begin
    if (reset || start_frame) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign o_valid = vld_p2;
  assign o_pixel = pix_p2;
  assign o_sof   = vld_p2 && (col == '0) && (row == '0);
  assign o_eol   = vld_p2 && (col == LAST_COL);
  assign o_eof   = vld_p2 && last_px;
  assign o_busy  = (state == STREAM);
  assign o_done  = (state == DONE);

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Self-checking bench for image_pixel_streamer: scoreboard of expected pixels
// per frame, table of frame scenarios, and hand sequences for reset/latency.
module tb_image_pixel_streamer;

  localparam int BW = 8;
  localparam int IX = 28;
  localparam int IY = 28;
  localparam int NP = IX * IY;
  localparam int AW = $clog2(NP);

  logic          clk;
  logic          reset;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [BW-1:0] i_wr_data;
  logic          i_start;
  logic          i_ready;
  logic          o_valid;
  logic [BW-1:0] o_pixel;
  logic          o_sof;
  logic          o_eol;
  logic          o_eof;
  logic          o_busy;
  logic          o_done;

  image_pixel_streamer #(.I_F_BW(BW), .IX(IX), .IY(IY), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_ready(i_ready),
    .o_valid(o_valid), .o_pixel(o_pixel), .o_sof(o_sof), .o_eol(o_eol),
    .o_eof(o_eof), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] pixel;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  typedef struct {
    int ready_pct;
    int abort_at;
    int blk_at;
    int exp_xfers;
    int exp_dones;
  } frame_vec_t;

  exp_t          sb[$];
  logic [BW-1:0] img [NP];
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit awaiting = 0;
  bit done_phase = 0;
  bit hold = 0;
  logic [BW+3:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples at negedge; a transfer happens at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      hold = 0;
      awaiting = 0;
      done_phase = 0;
    end else begin
      if (o_done || done_phase) check("done_pulse", 32'(o_done), 32'(done_phase));
      if (o_done) done_cnt++;
      if (done_phase) check("end_drop", {o_valid, o_busy}, 2'b00);
      done_phase = 0;
      if (hold) check("stall_hold", {o_valid, o_sof, o_eol, o_eof, o_pixel}, held);
      if (awaiting && o_valid) begin
        check("first_latency", 32'(cyc - start_cyc), 32'd2);
        awaiting = 0;
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", 32'(o_pixel), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          check("pixel_flags", {o_pixel, o_sof, o_eol, o_eof}, e);
          if (e.eof) done_phase = 1;
        end
        xfer_cnt++;
      end
      hold = o_valid && !i_ready;
      held = {o_valid, o_sof, o_eol, o_eof, o_pixel};
    end
  end

  task automatic run_frame(input frame_vec_t v);
    int x0;
    int d0;
    bit blk_done;
    exp_t e;
    x0 = xfer_cnt;
    d0 = done_cnt;
    blk_done = 0;
    for (int i = 0; i < NP; i++) begin
      e.pixel = img[i];
      e.sof   = (i == 0);
      e.eol   = ((i % IX) == IX - 1);
      e.eof   = (i == NP - 1);
      sb.push_back(e);
    end
    i_start = 1'b1;
    start_cyc = cyc + 1;
    awaiting = 1;
    @(posedge clk) #1;
    i_start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (done_cnt != d0) break;
      if (v.abort_at >= 0 && xfer_cnt - x0 >= v.abort_at) begin
        i_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_zero", {o_valid, o_pixel, o_sof, o_eol, o_eof, o_busy, o_done}, '0);
        repeat (8) @(posedge clk);
        #1;
        break;
      end
      i_ready = (v.ready_pct >= 100) || ($urandom_range(99) < v.ready_pct);
      if (v.blk_at >= 0 && !blk_done && xfer_cnt - x0 >= v.blk_at) begin
        i_start   = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_addr = '0;
        i_wr_data = 8'hAA;
        blk_done  = 1;
      end else begin
        i_start = 1'b0;
        i_wr_en = 1'b0;
      end
      @(posedge clk) #1;
    end
    i_start = 1'b0;
    i_wr_en = 1'b0;
    check("frame_xfers", 32'(xfer_cnt - x0), 32'(v.exp_xfers));
    check("frame_dones", 32'(done_cnt - d0), 32'(v.exp_dones));
    if (v.abort_at < 0) check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    frame_vec_t tbl[6];
    tbl[0] = '{ready_pct: 100, abort_at: -1,  blk_at: -1,  exp_xfers: NP,  exp_dones: 1};
    tbl[1] = '{ready_pct: 50,  abort_at: -1,  blk_at: -1,  exp_xfers: NP,  exp_dones: 1};
    tbl[2] = '{ready_pct: 100, abort_at: -1,  blk_at: 100, exp_xfers: NP,  exp_dones: 1};
    tbl[3] = '{ready_pct: 100, abort_at: 400, blk_at: -1,  exp_xfers: 400, exp_dones: 0};
    tbl[4] = '{ready_pct: 100, abort_at: -1,  blk_at: -1,  exp_xfers: NP,  exp_dones: 1};
    tbl[5] = '{ready_pct: 30,  abort_at: -1,  blk_at: 300, exp_xfers: NP,  exp_dones: 1};

    reset = 1'b1;
    i_wr_en = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_start = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pixel", 32'(o_pixel), 32'd0);
    check("rst_flags", {o_sof, o_eol, o_eof}, 3'b000);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_done",  32'(o_done),  32'd0);
    @(posedge clk) #1;
    reset = 1'b0;

    for (int i = 0; i < NP; i++) begin
      img[i] = BW'((i + 1) % 256);
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(i);
      i_wr_data = img[i];
      @(posedge clk) #1;
    end
    i_wr_addr = AW'(NP);
    i_wr_data = 8'h55;
    @(posedge clk) #1;
    i_wr_en = 1'b0;
    @(negedge clk);
    check("idle_after_load", {o_valid, o_busy, o_done}, 3'b000);
    @(posedge clk) #1;

    // Frames run back to back: each start lands two cycles after the previous done.
    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("final_idle", {o_valid, o_busy, o_done}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
